seq_nibble_mult: RTL and testbench

Parametrised sequential multiplier that accepts both operands as narrow serial segments (default nibble-wide), then multiplies them with a radix-2 shift-add datapath and presents a registered double-width product. It generalises our fixed 4x4 combinational array multiplier and nibble-serial instruction loader into one reusable block. It is meant to sit behind the narrow `ui_in` pin interface of a top-level tile, or as a PCPI-style arithmetic coprocessor.

---
 rtl/seq_nibble_mult_if.sv | 25 ++
 rtl/seq_nibble_mult.sv | 194 +++++++++++++++++++
 tb/tb_seq_nibble_mult.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seq_nibble_mult_if.sv
// Segment-load / result bus of seq_nibble_mult. The master drives segments and
// the signed_mode flag; the slave (the multiplier) returns handshake, status and product.
interface seq_nibble_mult_if #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
);
  logic                 seg_valid;
  logic [SEG-1:0]       seg_data;
  logic                 seg_ready;
  logic                 signed_mode;
  logic                 busy;
  logic                 done;
  logic                 result_valid;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output seg_valid, seg_data, signed_mode,
    input  seg_ready, busy, done, result_valid, product
  );

  modport slave (
    input  seg_valid, seg_data, signed_mode,
    output seg_ready, busy, done, result_valid, product
  );
endinterface

// File: rtl/seq_nibble_mult.sv
// Segment-loaded radix-2 shift-add multiplier with a registered double-width product.
// Optional two's-complement support is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_nibble_mult #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_nibble_mult_if.slave  bus
);

  localparam int NSEG   = WIDTH / SEG;
  localparam int CNT_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int ITER_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_SEG  = CNT_W'(NSEG - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_MULT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_seg_ready;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_accept;
  logic                 w_last_seg;
  logic                 w_mult_entry;

  logic [CNT_W-1:0]     r_seg_cnt;
  logic [ITER_W-1:0]    r_iter;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_result_valid;

  logic [WIDTH-1:0]     w_a_nxt;
  logic [WIDTH-1:0]     w_b_nxt;
  logic [WIDTH-1:0]     w_mcand_init;
  logic [WIDTH-1:0]     w_mplier_init;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [2*WIDTH-1:0]   w_product_fin;

`ifdef SEQ_MULT_SIGNED_EN
  logic                 r_neg;
  logic                 w_neg_init;

  // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits once the result is read as unsigned.
  function automatic logic [WIDTH-1:0] f_magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [2*WIDTH-1:0] f_negate(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction
`else
  logic                 w_unused_signed_mode;
  assign w_unused_signed_mode = bus.signed_mode;
`endif

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD_A;
    else     r_state <= w_state_nxt;
  end

  assign w_last_seg   = (r_seg_cnt == LAST_SEG);
  assign w_accept     = bus.seg_valid && w_seg_ready;
  assign w_mult_entry = w_accept && (r_state == S_LOAD_B) && w_last_seg;

  always_comb begin
    w_state_nxt = r_state;
    w_seg_ready = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_LOAD_A: begin
        w_seg_ready = 1'b1;
        if (bus.seg_valid && w_last_seg) w_state_nxt = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_seg_ready = 1'b1;
        if (bus.seg_valid && w_last_seg) w_state_nxt = S_MULT;
      end
      S_MULT: begin
        w_busy = 1'b1;
        if (r_iter == LAST_ITER) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_LOAD_A;
      end
      default: w_state_nxt = S_LOAD_A;
    endcase
  end

  // ---- operand assembly: incoming segment merged into its slot ----
  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    for (int k = 0; k < NSEG; k++) begin
      if (r_seg_cnt == CNT_W'(k)) begin
        w_a_nxt[k*SEG +: SEG] = bus.seg_data;
        w_b_nxt[k*SEG +: SEG] = bus.seg_data;
      end
    end
  end

  // The multiplier is taken from w_b_nxt so MULT can start on the edge that
  // accepts the last B segment.
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    w_mcand_init  = bus.signed_mode ? f_magnitude($signed(r_a))     : r_a;
    w_mplier_init = bus.signed_mode ? f_magnitude($signed(w_b_nxt)) : w_b_nxt;
    w_neg_init    = bus.signed_mode && (r_a[WIDTH-1] ^ w_b_nxt[WIDTH-1]);
`else
    w_mcand_init  = r_a;
    w_mplier_init = w_b_nxt;
`endif
  end

  // ---- shift-add iteration: WIDTH+1-bit sum keeps the carry ----
  always_comb begin
    w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    if (r_acc[0]) w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
    else          w_acc_step = {1'b0, r_acc[2*WIDTH-1:1]};
`ifdef SEQ_MULT_SIGNED_EN
    w_product_fin = r_neg ? f_negate(w_acc_step) : w_acc_step;
`else
    w_product_fin = w_acc_step;
`endif
  end

  // ---- datapath and result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_cnt      <= '0;
      r_iter         <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_mcand        <= '0;
      r_acc          <= '0;
      r_product      <= '0;
      r_result_valid <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg          <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_seg_cnt <= w_last_seg ? '0 : r_seg_cnt + 1'b1;
        if (r_state == S_LOAD_A) begin
          r_a <= w_a_nxt;
          if (r_seg_cnt == '0) r_result_valid <= 1'b0;
        end else begin
          r_b <= w_b_nxt;
        end
      end

      if (w_mult_entry) begin
        r_iter  <= '0;
        r_mcand <= w_mcand_init;
        r_acc   <= {{WIDTH{1'b0}}, w_mplier_init};
`ifdef SEQ_MULT_SIGNED_EN
        r_neg   <= w_neg_init;
`endif
      end

      // The final iteration writes the product directly so it is visible in DONE.
      if (r_state == S_MULT) begin
        r_iter <= r_iter + 1'b1;
        r_acc  <= w_acc_step;
        if (r_iter == LAST_ITER) begin
          r_product      <= w_product_fin;
          r_result_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.seg_ready    = w_seg_ready;
  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.result_valid = r_result_valid;
  assign bus.product      = r_product;

endmodule

// File: tb/tb_seq_nibble_mult.sv
// Randomised self-checking bench for seq_nibble_mult (WIDTH=8, SEG=4) against an
// arithmetic reference model; the model follows SEQ_MULT_SIGNED_EN when defined.
module tb_seq_nibble_mult;

  localparam int WIDTH = 8;
  localparam int SEG   = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [15:0] last_prod;

  seq_nibble_mult_if #(.WIDTH(WIDTH), .SEG(SEG)) u_if ();

  seq_nibble_mult #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int ua;
    int ub;
`ifdef SEQ_MULT_SIGNED_EN
    if (sm) begin
      ua = int'($signed(a));
      ub = int'($signed(b));
      return 16'(ua * ub);
    end
`endif
    ua = int'(a);
    ub = int'(b);
    return 16'(ua * ub);
  endfunction

  // Entered and left on a negedge; the posedge in between accepts the segment.
  task automatic send_seg(input logic [3:0] d, input int gap);
    int guard;
    guard = 0;
    repeat (gap) begin
      u_if.seg_valid = 1'b0;
      u_if.seg_data  = 4'($urandom);
      @(negedge clk);
    end
    u_if.seg_valid = 1'b1;
    u_if.seg_data  = d;
    while (!u_if.seg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_val("ready_timeout", 32'(u_if.seg_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic load_operands(input logic [7:0] a, input logic [7:0] b, input logic sm,
                               input int gap, input logic check_first);
    u_if.signed_mode = sm;
    send_seg(a[3:0], gap);
    if (check_first) begin
      check_val("first_a_clears_valid", 32'(u_if.result_valid), 32'd0);
      check_val("first_a_holds_product", 32'(u_if.product), 32'(last_prod));
    end
    send_seg(a[7:4], gap);
    send_seg(b[3:0], gap);
    u_if.signed_mode = ~sm;
    send_seg(b[7:4], 0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input int gap, input logic hold);
    logic [15:0] exp_p;
    int lat;
    exp_p = ref_product(a, b, sm);
    u_if.signed_mode = sm;
    u_if.signed_mode = sm;
    send_seg(a[3:0], gap);
    check_val("first_a_clears_valid", 32'(u_if.result_valid), 32'd0);
    check_val("first_a_holds_product", 32'(u_if.product), 32'(last_prod));
    send_seg(a[7:4], gap);
    send_seg(b[3:0], gap);
    send_seg(b[7:4], gap);
    u_if.signed_mode = $urandom_range(0, 1);
    u_if.seg_valid   = hold;
    u_if.seg_data    = 4'($urandom);
    lat = 1;
    check_val("mult_busy", 32'(u_if.busy), 32'd1);
    check_val("mult_not_ready", 32'(u_if.seg_ready), 32'd0);
    while (!u_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("done_latency", 32'(lat), 32'(WIDTH + 1));
    check_val("product", 32'(u_if.product), 32'(exp_p));
    check_val("result_valid_at_done", 32'(u_if.result_valid), 32'd1);
    @(negedge clk);
    check_val("done_single_pulse", 32'(u_if.done), 32'd0);
    check_val("ready_after_done", 32'(u_if.seg_ready), 32'd1);
    check_val("product_holds", 32'(u_if.product), 32'(exp_p));
    u_if.seg_valid = 1'b0;
    last_prod = exp_p;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_prod = 16'h0000;
    rst = 1'b1;
    u_if.seg_valid   = 1'b0;
    u_if.seg_data    = 4'h0;
    u_if.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_ready", 32'(u_if.seg_ready), 32'd1);
    check_val("reset_product", 32'(u_if.product), 32'h0000);
    check_val("reset_result_valid", 32'(u_if.result_valid), 32'd0);
    check_val("reset_busy", 32'(u_if.busy), 32'd0);
    check_val("reset_done", 32'(u_if.done), 32'd0);

    run_op(8'h0F, 8'h11, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h7F, 1'b1, 0, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 0, 1'b1);
    run_op(8'hA5, 8'h3C, 1'b0, 3, 1'b1);
    run_op(8'hA5, 8'h3C, 1'b0, 3, 1'b0);
    run_op(8'h00, 8'h9B, 1'b1, 1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted during the fourth MULT cycle.
    u_if.signed_mode = 1'b0;
    send_seg(4'h7, 0);
    send_seg(4'hC, 0);
    send_seg(4'h3, 0);
    send_seg(4'hE, 0);
    u_if.seg_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_val("mult4_busy", 32'(u_if.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    u_if.seg_valid = 1'b0;
    check_val("midrst_ready", 32'(u_if.seg_ready), 32'd1);
    check_val("midrst_busy", 32'(u_if.busy), 32'd0);
    check_val("midrst_done", 32'(u_if.done), 32'd0);
    check_val("midrst_result_valid", 32'(u_if.result_valid), 32'd0);
    check_val("midrst_product", 32'(u_if.product), 32'h0000);
    last_prod = 16'h0000;
    run_op(8'h03, 8'h05, 1'b0, 0, 1'b0);
    check_val("fresh_after_reset", 32'(last_prod), 32'h000F);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
